// File: rtl/serial_borrow_subtractor.sv
// Digit-serial subtractor: Diff = A - B - borrow_in (mod 2^WIDTH), DIGIT bits per clock, LSB first.
// Start/busy/done handshake; outputs are only written when an operation completes.
module serial_borrow_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             bw, bw_nx, chain;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic             accept, last;
  logic [DIGIT-1:0] dig;

  // One extra RUN cycle (cnt == NDIG) commits the result, giving done at start+NDIG+1.
  always_comb begin
    accept   = start && (state == IDLE || state == DONE);
    last     = (cnt == CW'(NDIG));
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    chain = bw;
    dig   = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dig[i] = a_sh[i] ^ b_sh[i] ^ chain;
      chain  = (~a_sh[i] & b_sh[i]) | (~a_sh[i] & chain) | (b_sh[i] & chain);
    end
    bw_nx = chain;
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      Diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh   <= A;
        b_sh   <= B;
        bw     <= borrow_in;
        cnt    <= '0;
        res_sh <= '0;
        a_msb  <= A[WIDTH-1];
        b_msb  <= B[WIDTH-1];
      end else if (state == RUN) begin
        if (!last) begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= (res_sh >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
          bw     <= bw_nx;
          cnt    <= cnt + 1'b1;
        end else begin
          Diff       <= res_sh;
          borrow_out <= bw;
          overflow   <= (a_msb != b_msb) && (res_sh[WIDTH-1] != a_msb);
        end
      end
    end
  end

endmodule
